// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_EXT = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side bundle of the memory arbiter: two req/ack ports with
// separate write and read data.
interface mem_arb_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, ack1, rdata1
    );

endinterface

// File: rtl/arb_rr2.sv
// Combinational two-way picker: a lone requester wins; a tie goes to port 0
// under fixed priority, otherwise to the port that was not granted last.
module arb_rr2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (eligible)
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                if (fixed_prio) begin
                    grant_idx = 1'b0;
                end else begin
                    grant_idx = ~last_grant;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported word memory between two req/ack masters. Every access
// runs IDLE -> ACCESS (-> DATA for reads); CS/WE/ADDR and the bus drive are registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              CLK,
    input  logic              RST,
    mem_arb_if.slave          ports,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Mem_Bus
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              cs_q, cs_d;
    logic              mem_we_q, mem_we_d;
    logic              drive_q, drive_d;

    logic [1:0]        eligible_s;
    logic              grant_valid_s;
    logic              grant_idx_s;

    // A port whose ack is high this cycle is masked so it cannot be re-granted on stale req.
    assign eligible_s = {ports.req1 & ~ack_q[1], ports.req0 & ~ack_q[0]};

    arb_rr2 u_pick (
        .eligible    (eligible_s),
        .last_grant  (last_grant_q),
        .fixed_prio  (FIXED_PRIO != 0),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        ack_d        = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        cs_d         = 1'b0;
        mem_we_d     = 1'b0;
        drive_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    owner_d      = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    if (grant_idx_s == PORT_EXT) begin
                        addr_d  = ports.addr1;
                        we_d    = ports.we1;
                        wdata_d = ports.wdata1;
                    end else begin
                        addr_d  = ports.addr0;
                        we_d    = ports.we0;
                        wdata_d = ports.wdata0;
                    end
                    cs_d     = 1'b1;
                    mem_we_d = we_d;
                    drive_d  = we_d;
                    state_d  = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    ack_d[owner_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cs_d    = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                ack_d[owner_q] = 1'b1;
                if (owner_q == PORT_EXT) begin
                    rdata1_d = Mem_Bus;
                end else begin
                    rdata0_d = Mem_Bus;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset aborts any access in flight: CS/WE and the bus drive fall immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_q      <= PORT_CPU;
            addr_q       <= {ADDR_W{1'b0}};
            we_q         <= 1'b0;
            wdata_q      <= {DATA_W{1'b0}};
            last_grant_q <= 1'b1;
            ack_q        <= 2'b00;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
            cs_q         <= 1'b0;
            mem_we_q     <= 1'b0;
            drive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            cs_q         <= cs_d;
            mem_we_q     <= mem_we_d;
            drive_q      <= drive_d;
        end
    end

    assign CS           = cs_q;
    assign WE           = mem_we_q;
    assign ADDR         = addr_q;
    assign Mem_Bus      = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign ports.ack0   = ack_q[0];
    assign ports.ack1   = ack_q[1];
    assign ports.rdata0 = rdata0_q;
    assign ports.rdata1 = rdata1_q;

endmodule
